// File: rtl/pcs_rx_link_ctrl.sv
// 10GBASE-R receive bring-up controller: sequences PMA/PCS resets, waits for CDR and
// block lock, runs the high-BER monitor on sync headers and publishes link_up.
module pcs_rx_link_ctrl #(
   parameter int PMA_RST_CYCLES = 64,
   parameter int LOCK_TIMEOUT   = 1048576,
   parameter int HIBER_WINDOW   = 40283,
   parameter int HIBER_THRESH   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pma_rx_ready,
   input  logic [1:0]  header,
   input  logic        header_ena,
   input  logic        block_lock,
   input  logic        stat_clr,
   output logic        pma_rx_rst,
   output logic        pcs_rst,
   output logic        hi_ber,
   output logic        link_up,
   output logic [1:0]  state,
   output logic [15:0] err_cnt,
   output logic [7:0]  retrain_cnt
);

   localparam int TMR_MAX = (LOCK_TIMEOUT > PMA_RST_CYCLES) ? LOCK_TIMEOUT : PMA_RST_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int WIN_W   = $clog2(HIBER_WINDOW + 1);
   localparam int BER_W   = $clog2(HIBER_THRESH + 1);

   typedef enum logic [1:0] {
      RESET_PMA = 2'd0,
      WAIT_CDR  = 2'd1,
      WAIT_LOCK = 2'd2,
      LINK_UP   = 2'd3
   } state_t;

   state_t             state_q, state_nxt;
   logic [TMR_W-1:0]   timer_q, timer_nxt;
   logic [WIN_W-1:0]   win_q, win_nxt;
   logic [BER_W-1:0]   ber_q, ber_nxt, ber_inc;
   logic               hi_ber_nxt;
   logic               retrain_evt;
   logic               inv_hdr;
   logic               win_last;
   logic [1:0]         sync_q;
   logic               run;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
      return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
      return (en && (v != 8'hFF)) ? v + 8'd1 : v;
   endfunction

   function automatic logic [BER_W-1:0] sat_ber(input logic [BER_W-1:0] v, input logic en);
      return (en && (v != BER_W'(HIBER_THRESH))) ? v + 1'b1 : v;
   endfunction

   // Reset release is synchronised; the controller only advances once it has passed both flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= 2'b00;
      else      sync_q <= {sync_q[0], 1'b1};
   end
   assign run = sync_q[1];

   always_comb begin
      state_nxt   = state_q;
      timer_nxt   = timer_q + 1'b1;
      retrain_evt = 1'b0;
      case (state_q)
         RESET_PMA: begin
            if (timer_q == TMR_W'(PMA_RST_CYCLES - 1)) begin
               state_nxt = WAIT_CDR;
               timer_nxt = '0;
            end
         end
         WAIT_CDR: begin
            timer_nxt = '0;
            if (pma_rx_ready) state_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (!pma_rx_ready) begin
               state_nxt = RESET_PMA;
               timer_nxt = '0;
            end else if (block_lock) begin
               state_nxt = LINK_UP;
               timer_nxt = '0;
            end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
               state_nxt   = RESET_PMA;
               timer_nxt   = '0;
               retrain_evt = 1'b1;
            end
         end
         LINK_UP: begin
            timer_nxt = '0;
            if (!pma_rx_ready)    state_nxt = RESET_PMA;
            else if (!block_lock) state_nxt = WAIT_LOCK;
         end
         default: begin
            state_nxt = RESET_PMA;
            timer_nxt = '0;
         end
      endcase
   end

   assign inv_hdr  = header_ena && ((header == 2'b00) || (header == 2'b11));
   assign win_last = (win_q == WIN_W'(HIBER_WINDOW - 1));
   assign ber_inc  = sat_ber(ber_q, inv_hdr);

   // The window's last cycle re-evaluates hi_ber, counting an invalid header on that cycle too.
   always_comb begin
      win_nxt    = win_q;
      ber_nxt    = ber_q;
      hi_ber_nxt = hi_ber;
      if (!block_lock) begin
         win_nxt    = '0;
         ber_nxt    = '0;
         hi_ber_nxt = 1'b0;
      end else if (win_last) begin
         win_nxt    = '0;
         ber_nxt    = '0;
         hi_ber_nxt = (({1'b0, ber_q} + (BER_W+1)'(inv_hdr)) >= (BER_W+1)'(HIBER_THRESH));
      end else begin
         win_nxt = win_q + 1'b1;
         ber_nxt = ber_inc;
         if (ber_inc == BER_W'(HIBER_THRESH)) hi_ber_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RESET_PMA;
         timer_q     <= '0;
         pma_rx_rst  <= 1'b1;
         pcs_rst     <= 1'b1;
         win_q       <= '0;
         ber_q       <= '0;
         hi_ber      <= 1'b0;
         link_up     <= 1'b0;
         err_cnt     <= '0;
         retrain_cnt <= '0;
      end else if (run) begin
         state_q     <= state_nxt;
         timer_q     <= timer_nxt;
         pma_rx_rst  <= (state_nxt == RESET_PMA);
         pcs_rst     <= (state_nxt == RESET_PMA) || (state_nxt == WAIT_CDR);
         win_q       <= win_nxt;
         ber_q       <= ber_nxt;
         hi_ber      <= hi_ber_nxt;
         link_up     <= (state_q == LINK_UP) && block_lock && !hi_ber_nxt;
         err_cnt     <= stat_clr ? 16'd0 : sat_inc16(err_cnt, inv_hdr && block_lock);
         retrain_cnt <= stat_clr ? 8'd0  : sat_inc8(retrain_cnt, retrain_evt);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_pcs_rx_link_ctrl.sv
// Directed bench for pcs_rx_link_ctrl: bring-up, BER windows, lock loss, timeouts,
// counter saturation/clear and asynchronous reset.
module tb_pcs_rx_link_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pma_rx_ready = 1'b0;
   logic [1:0]  header = 2'b01;
   logic        header_ena = 1'b0;
   logic        block_lock = 1'b0;
   logic        stat_clr = 1'b0;
   logic        pma_rx_rst, pcs_rst, hi_ber, link_up;
   logic [1:0]  state;
   logic [15:0] err_cnt;
   logic [7:0]  retrain_cnt;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int cyc_a  = 0;

   always #5 clk = ~clk;

   pcs_rx_link_ctrl #(
      .PMA_RST_CYCLES(64),
      .LOCK_TIMEOUT  (1000),
      .HIBER_WINDOW  (1000),
      .HIBER_THRESH  (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pma_rx_ready(pma_rx_ready),
      .header      (header),
      .header_ena  (header_ena),
      .block_lock  (block_lock),
      .stat_clr    (stat_clr),
      .pma_rx_rst  (pma_rx_rst),
      .pcs_rst     (pcs_rst),
      .hi_ber      (hi_ber),
      .link_up     (link_up),
      .state       (state),
      .err_cnt     (err_cnt),
      .retrain_cnt (retrain_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick_to(input int rel);
      while (cyc - cyc_a < rel) tick();
   endtask

   task automatic wait_state(input logic [1:0] s, input int max, input string tag);
      int n = 0;
      while (state !== s && n < max) begin
         tick();
         n++;
      end
      chk(tag, 32'(state), 32'(s));
   endtask

   task automatic inject(input int n, input logic [1:0] h);
      header     = h;
      header_ena = 1'b1;
      repeat (n) tick();
      header_ena = 1'b0;
      header     = 2'b01;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_pma_rx_rst"},  32'(pma_rx_rst),  32'd1);
      chk({tag, "_pcs_rst"},     32'(pcs_rst),     32'd1);
      chk({tag, "_hi_ber"},      32'(hi_ber),      32'd0);
      chk({tag, "_link_up"},     32'(link_up),     32'd0);
      chk({tag, "_state"},       32'(state),       32'd0);
      chk({tag, "_err_cnt"},     32'(err_cnt),     32'd0);
      chk({tag, "_retrain_cnt"}, 32'(retrain_cnt), 32'd0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      repeat (3) tick();
      check_reset("rst");

      // Bring-up
      rst = 1'b1;
      repeat (10) tick();
      pma_rx_ready = 1'b1;
      wait_state(2'd1, 200, "bring_state1");
      chk("bring_pma_rst_low", 32'(pma_rx_rst), 32'd0);
      chk("bring_pcs_rst_hold", 32'(pcs_rst), 32'd1);
      tick();
      chk("bring_state2", 32'(state), 32'd2);
      chk("bring_pcs_rst_low", 32'(pcs_rst), 32'd0);
      repeat (99) tick();
      chk("bring_wait_lock_hold", 32'(state), 32'd2);
      block_lock = 1'b1;
      tick();
      cyc_a = cyc;
      chk("bring_state3", 32'(state), 32'd3);
      chk("bring_link_lag", 32'(link_up), 32'd0);
      tick();
      chk("bring_link_up", 32'(link_up), 32'd1);
      chk("bring_retrain", 32'(retrain_cnt), 32'd0);

      // High BER: 16 errors in one window, then a 15-error window
      inject(15, 2'b00);
      chk("ber_15_no_hi", 32'(hi_ber), 32'd0);
      inject(1, 2'b00);
      chk("ber_16_hi", 32'(hi_ber), 32'd1);
      chk("ber_16_link_down", 32'(link_up), 32'd0);
      chk("ber_16_err_cnt", 32'(err_cnt), 32'd16);
      tick_to(1000);
      chk("ber_hold_win_end", 32'(hi_ber), 32'd1);
      inject(15, 2'b11);
      tick_to(1998);
      chk("ber_hold_pre_end", 32'(hi_ber), 32'd1);
      tick();
      chk("ber_clear_win_end", 32'(hi_ber), 32'd0);
      chk("ber_clear_link_up", 32'(link_up), 32'd1);
      chk("ber_err_cnt_31", 32'(err_cnt), 32'd31);

      // Boundary: 16th error on the last window cycle, next error belongs to next window
      inject(15, 2'b00);
      chk("bnd_15_no_hi", 32'(hi_ber), 32'd0);
      tick_to(2998);
      inject(1, 2'b00);
      chk("bnd_last_cycle_hi", 32'(hi_ber), 32'd1);
      inject(16, 2'b11);
      tick_to(3999);
      chk("bnd_next_window_16", 32'(hi_ber), 32'd1);
      chk("bnd_err_cnt", 32'(err_cnt), 32'd63);

      // Lock loss, relock, then CDR and lock drop together
      block_lock = 1'b0;
      tick();
      chk("loss_state", 32'(state), 32'd2);
      chk("loss_hi_ber", 32'(hi_ber), 32'd0);
      chk("loss_link_up", 32'(link_up), 32'd0);
      block_lock = 1'b1;
      tick();
      chk("relock_state", 32'(state), 32'd3);
      tick();
      chk("relock_link_up", 32'(link_up), 32'd1);
      pma_rx_ready = 1'b0;
      block_lock   = 1'b0;
      tick();
      chk("cdr_drop_state", 32'(state), 32'd0);
      chk("cdr_drop_pma_rst", 32'(pma_rx_rst), 32'd1);
      chk("cdr_drop_no_retrain", 32'(retrain_cnt), 32'd0);

      // RESET_PMA length and lock timeouts
      pma_rx_ready = 1'b1;
      n = 1;
      tick();
      while (state == 2'd0 && n < 200) begin
         n++;
         tick();
      end
      chk("pma_rst_len", 32'(n), 32'd64);
      chk("pma_rst_released", 32'(pma_rx_rst), 32'd0);
      n = 0;
      while (state != 2'd0 && n < 3000) begin
         tick();
         n++;
      end
      chk("timeout1_len", 32'(n), 32'd1001);
      chk("timeout1_retrain", 32'(retrain_cnt), 32'd1);
      for (int k = 2; k <= 3; k++) begin
         n = 0;
         while (state == 2'd0 && n < 3000) begin
            tick();
            n++;
         end
         while (state != 2'd0 && n < 3000) begin
            tick();
            n++;
         end
         chk($sformatf("timeout%0d_period", k), 32'(n), 32'd1065);
         chk($sformatf("timeout%0d_retrain", k), 32'(retrain_cnt), 32'(k));
      end

      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("clr_retrain", 32'(retrain_cnt), 32'd0);
      chk("clr_err_cnt", 32'(err_cnt), 32'd0);

      // err_cnt saturation and clear-wins
      block_lock = 1'b1;
      header     = 2'b11;
      header_ena = 1'b1;
      repeat (65540) tick();
      chk("sat_err_cnt", 32'(err_cnt), 32'd65535);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("sat_clr_wins", 32'(err_cnt), 32'd0);
      tick();
      chk("sat_count_resumes", 32'(err_cnt), 32'd1);
      header_ena = 1'b0;
      header     = 2'b01;
      repeat (2100) tick();
      chk("pre_async_state", 32'(state), 32'd3);
      chk("pre_async_link_up", 32'(link_up), 32'd1);

      // Asynchronous reset mid-LINK_UP, checked before any further clock edge
      rst = 1'b0;
      #1;
      check_reset("async");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pcs_rx_link_ctrl.md
# pcs_rx_link_ctrl

Bring-up and link-health controller for the 32-bit 10GBASE-R receive path. It sequences the transceiver RX reset and the PCS RX datapath reset, and waits for CDR lock and then for block lock. It runs the Clause 49 high-BER monitor on the 2-bit sync headers and publishes `link_up`. A retrain is forced when block lock is not reached within a timeout. It sits beside the PCS RX chain: sync headers and block lock come in from it, and reset commands go back out to the PMA and the PCS datapath.

## Interface
Parameters:
- `PMA_RST_CYCLES`, 64 — cycles `pma_rx_rst` is held in RESET_PMA.
- `LOCK_TIMEOUT`, 1048576 — cycles in WAIT_LOCK before a forced retrain.
- `HIBER_WINDOW`, 40283 — clk cycles per BER window (125 µs at 322.27 MHz).
- `HIBER_THRESH`, 16 — invalid headers within one window that assert `hi_ber`.

Ports:
- `clk`  in  1  — PCS RX clock, the only clock.
- `rst`  in  1  — asynchronous reset, active-low (0 = reset).
- `pma_rx_ready`  in  1  — transceiver CDR/RX ready. Level, synchronous to `clk`.
- `header`  in  2  — sync header of the current 66b block.
- `header_ena`  in  1  — `header` is valid this cycle.
- `block_lock`  in  1  — block-sync lock from the PCS RX chain.
- `stat_clr`  in  1  — one-cycle pulse that clears the statistics counters.
- `pma_rx_rst`  out  1  — active-high reset to the transceiver RX.
- `pcs_rst`  out  1  — active-high synchronous reset to the PCS RX datapath.
- `hi_ber`  out  1  — high-BER condition.
- `link_up`  out  1  — link usable.
- `state`  out  2  — FSM state: 0 = RESET_PMA, 1 = WAIT_CDR, 2 = WAIT_LOCK, 3 = LINK_UP.
- `err_cnt`  out  16  — saturating count of invalid headers.
- `retrain_cnt`  out  8  — saturating count of forced retrains.

## Operation
- All outputs are registered.
- Reset values: `pma_rx_rst`=1, `pcs_rst`=1, `hi_ber`=0, `link_up`=0, `state`=RESET_PMA, all counters 0.

State machine, one shared timer:
- **RESET_PMA:** `pma_rx_rst`=1, `pcs_rst`=1. Timer counts `PMA_RST_CYCLES`, then go to WAIT_CDR and clear the timer.
- **WAIT_CDR:** `pma_rx_rst`=0, `pcs_rst`=1. On `pma_rx_ready`=1, go to WAIT_LOCK and clear the timer. No timeout.
- **WAIT_LOCK:** `pcs_rst`=0.
  - `block_lock`=1: go to LINK_UP.
  - Timer reaches `LOCK_TIMEOUT`-1 without lock: go to RESET_PMA and increment `retrain_cnt`.
  - `pma_rx_ready`=0: go to RESET_PMA. This does not count as a retrain.
- **LINK_UP:**
  - `block_lock`=0: go to WAIT_LOCK and clear the timer.
  - `pma_rx_ready`=0: go to RESET_PMA.
  - If both conditions occur in the same cycle, `pma_rx_ready` takes priority.

BER monitor:
- Active only while `block_lock`=1.
- An invalid header is `header_ena`=1 with `header` equal to 2'b00 or 2'b11.
- A window counter counts clk cycles from 0 to `HIBER_WINDOW`-1. A per-window error counter saturates at `HIBER_THRESH`.
- Error counter reaches `HIBER_THRESH`: `hi_ber` is set on the next cycle.
- Last cycle of a window:
  - `hi_ber` = (window errors, including any invalid header in this cycle, ≥ `HIBER_THRESH`).
  - The window counter and the error counter both restart at 0.
- `block_lock`=0: the window counter, the error counter and `hi_ber` clear on the next cycle.

Outputs and statistics:
- `link_up` = (state==LINK_UP) && `block_lock` && !`hi_ber`, registered.
- `err_cnt` increments on every invalid header while `block_lock`=1 and saturates at 16'hFFFF.
- `stat_clr` clears `err_cnt` and `retrain_cnt`. If `stat_clr` coincides with an increment, the clear wins and the result is 0.
- Reset assertion mid-operation forces all outputs to their reset values immediately (asynchronously).

## Timing
- State change is visible on `state` in the cycle after the triggering input is sampled.
- `pma_rx_rst` and `pcs_rst` change in the same cycle as `state`.
- `pma_rx_rst` is high for exactly `PMA_RST_CYCLES` cycles after reset release or after entering RESET_PMA.
- `link_up` follows its terms with one cycle of latency, so it trails the `state` change into LINK_UP by one cycle.
- `block_lock` fall in LINK_UP: `state`=WAIT_LOCK after 1 cycle and `link_up`=0 after 1 cycle.
- Reset deassertion is synchronised internally: the first FSM step occurs 2 cycles after `rst` rises.

## Test plan
- Bring-up: release `rst`; assert `pma_rx_ready` 10 cycles later and `block_lock` 100 cycles after that.
  - `pma_rx_rst` is high for 64 cycles.
  - `state` goes 0→1→2→3.
  - `link_up`=1 one cycle after `state`=3.
  - `retrain_cnt`=0.
- Lock timeout: `LOCK_TIMEOUT`=1000, `block_lock` held at 0.
  - RESET_PMA is re-entered every 1000+64+CDR cycles.
  - `retrain_cnt` reaches 3 after 3 timeouts.
- High BER: `HIBER_WINDOW`=1000; inject 16 headers of 2'b00 in one window.
  - `hi_ber`=1 and `link_up`=0 one cycle after the 16th.
  - A following window with 15 errors clears `hi_ber` at that window's end.
  - `err_cnt`=31.
- Boundary window error: 15 errors, then the 16th on the window's last cycle → `hi_ber`=1. An error on the first cycle of the next window counts toward the next window.
- Lock loss and CDR drop: drop `block_lock` in LINK_UP.
  - Next cycle: `state`=2, `hi_ber`=0, `link_up`=0.
  - Then drop `pma_rx_ready` and `block_lock` together → `state`=0.
- Counters: drive `err_cnt` to saturation (65535), then pulse `stat_clr` coincident with an invalid header → `err_cnt`=0. Assert `rst` mid-LINK_UP → all outputs return to reset values asynchronously.
